sccb_master_ctrl: RTL and testbench
===================================

// Module: sccb_master_ctrl
// PURPOSE
//  Parametrised SCCB (OmniVision 3-wire) command-level master: START, WRITE byte, READ byte, STOP.
//  Programmable SIO_C rate, valid/ready command port, per-command response pulse.
//  Sits between the camera-init sequencer and the open-drain pad cells for SIO_C/SIO_D/SCCB_E.
// PARAMETERS
//  CLK_DIV   100  sys_clk cycles per quarter-bit; one SIO_C bit = 4*CLK_DIV cycles; legal >=1
// PORTS
//  sys_clk    in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous reset, active-high
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  controller can accept a command (state IDLE or HOLD)
//  cmd_op     in   2  00 START, 01 WRITE, 10 READ, 11 STOP
//  cmd_data   in   8  byte for WRITE, MSB first; ignored otherwise
//  rsp_valid  out  1  one-cycle pulse on completion of every accepted command
//  rsp_data   out  8  READ result; 0 for other ops; held until next rsp_valid
//  rsp_err    out  1  qualifies rsp_valid: illegal op (or NACK, see CONFIGURATION)
//  busy       out  1  command in progress (= !cmd_ready)
//  sio_c      out  1  SCCB clock, push-pull
//  sio_d_i    in   1  SIO_D pad input
//  sio_d_oe   out  1  1 = pull SIO_D low, 0 = release (bus reads 1)
//  sccb_e     out  1  SCCB enable, active-low
// BEHAVIOUR
//  Reset (async, immediate, also mid-command): state IDLE, sio_c=1, sio_d_oe=0, sccb_e=1, cmd_ready=1,
//   busy=0, rsp_valid=0, rsp_data=0, rsp_err=0; divider/quarter/bit counters cleared.
//  Accept on cmd_valid&&cmd_ready (cycle N): op/data registered, ready drops at N+1, quarter 0 starts N+1.
//   Input changes after accept are ignored; cmd_valid while busy is not accepted.
//  Quarter advances every CLK_DIV cycles (tick); command latency = 1 + Q*CLK_DIV; Q=4 START/STOP, 36 WRITE/READ.
//  rsp_valid, cmd_ready=1 in first cycle after last quarter; back-to-back accept allowed that cycle.
//  States: IDLE(bus free) HOLD(bus owned, sio_c=0, oe held) START WRITE READ STOP.
//  START (from IDLE or HOLD = repeated start): q0 sio_c=0 oe=0 sccb_e=0; q1 sio_c=1; q2 oe=1; q3 sio_c=0 -> HOLD.
//  STOP (from HOLD): q0 sio_c=0 oe=1; q1 sio_c=1; q2 oe=0; q3 sccb_e=1 -> IDLE, sio_c stays 1.
//  Bit slot (9 per byte): q0 sio_c=0, update oe; q1,q2 sio_c=1; q3 sio_c=0. Sample sio_d_i on last cycle of q2.
//  WRITE: bits 1-8 oe=~data[7..0]; bit 9 oe=0 (don't-care/ACK slot) -> HOLD.
//  READ: bits 1-8 oe=0, sampled into shift reg MSB first; bit 9 oe=0 (NA=1) -> HOLD; rsp_data updated.
//  Illegal: WRITE/READ/STOP in IDLE -> no bus activity, rsp_valid+rsp_err=1 at N+1, stays IDLE.
//  sio_d_oe never changes while sio_c=1 except START q2 / STOP q2.
// CONFIGURATION
//  SCCB_ACK_CHECK_EN defined: WRITE samples bit 9; sampled 1 -> rsp_err=1 (NACK); state still -> HOLD.
//  Not defined: bit 9 not evaluated; rsp_err set only for illegal ops.
// STRUCTURE
//  sccb_pkg: op codes (SCCB_OP_START/WRITE/READ/STOP), state encoding, quarter indices, bit-count max (9).
//  Sub-module sccb_tick_gen: $clog2(CLK_DIV)-bit counter, tick every CLK_DIV cycles, cleared on accept.
//  Top: FSM, 2-bit quarter counter, 4-bit bit counter, 8-bit tx/rx shift regs, output regs (no glitches).
// TESTING  (CLK_DIV=4, open-drain bus model with pull-up, SCCB slave BFM)
//  After reset -> sio_c=1, sio_d_oe=0, sccb_e=1, cmd_ready=1, rsp_valid=0.
//  START, WRITE 0x42, STOP -> BFM sees start, byte 0x42 on sio_c rises, stop; WRITE busy 144 cycles; 3 rsp_valid, err=0.
//  START, READ with BFM driving 0xA5 -> rsp_data=0xA5, rsp_err=0, bit 9 sio_d_oe=0, ends in HOLD (sio_c=0).
//  WRITE in IDLE -> rsp_valid+rsp_err=1 one cycle after accept, sio_c/sccb_e never toggle.
//  rst pulsed during WRITE bit 4 -> outputs idle in same cycle; subsequent START/WRITE 0x0A/STOP correct.
//  BFM leaves bit 9 high on WRITE -> rsp_err=1 with SCCB_ACK_CHECK_EN, rsp_err=0 without.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB command-level master: op codes, FSM state
// encoding, quarter-bit indices, per-byte bit count and the pad output bundle.
// Ports: none (package).
package sccb_pkg;

    localparam int unsigned Q_W         = 2;
    localparam int unsigned BIT_W       = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BIT_CNT_MAX = 9;   // 8 data bits + ACK/NA slot

    localparam logic [Q_W-1:0] Q0 = 2'd0;
    localparam logic [Q_W-1:0] Q1 = 2'd1;
    localparam logic [Q_W-1:0] Q2 = 2'd2;
    localparam logic [Q_W-1:0] Q3 = 2'd3;

    typedef enum logic [1:0] {
        SCCB_OP_START = 2'b00,
        SCCB_OP_WRITE = 2'b01,
        SCCB_OP_READ  = 2'b10,
        SCCB_OP_STOP  = 2'b11
    } sccb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_START = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_STOP  = 3'd5
    } sccb_state_e;

    // Registered pad drive bundle
    typedef struct packed {
        logic sio_c;
        logic sio_d_oe;
        logic sccb_e;
    } sccb_pad_t;

    localparam sccb_pad_t PAD_IDLE = '{sio_c: 1'b1, sio_d_oe: 1'b0, sccb_e: 1'b1};

    // True when the bit counter points at the ACK/NA slot
    function automatic logic is_last_bit(input logic [BIT_W-1:0] bit_idx);
        return bit_idx == BIT_W'(BIT_CNT_MAX - 1);
    endfunction

endpackage

// File: rtl/sccb_master_ctrl_if.sv
// Command/response and pad signals of the SCCB master.
// master modport: the controller (drives ready/response/pads, reads command and sio_d_i).
// slave modport : the command source and pad model.
interface sccb_master_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       sio_c;
    logic       sio_d_i;
    logic       sio_d_oe;
    logic       sccb_e;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, sio_d_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, sio_c, sio_d_oe, sccb_e
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, sio_d_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, sio_c, sio_d_oe, sccb_e
    );

endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: o_tick_c is high for one cycle every CLK_DIV cycles.
// Ports: sys_clk, rst (async, active-high), i_clr (restart count, e.g. on accept),
//        o_tick_c (combinational decode of the counter).
module sccb_tick_gen #(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick_c = (r_cnt == CNT_LAST);

    // Divider counter; restart aligns quarter 0 to the cycle after accept
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sccb_master_ctrl.sv
// SCCB (3-wire) command-level master: START, WRITE byte, READ byte, STOP.
// Each bit is four quarters of CLK_DIV cycles; all pad and response outputs registered.
// Ports: sys_clk, rst (async, active-high), bus (sccb_master_ctrl_if.master):
//   cmd_valid/cmd_ready/cmd_op/cmd_data  command handshake
//   rsp_valid/rsp_data/rsp_err           one-cycle completion response
//   busy                                 inverse of cmd_ready
//   sio_c, sio_d_oe, sccb_e, sio_d_i     pad side
// Optional macro: SCCB_ACK_CHECK_EN - WRITE samples the ACK slot, a 1 reports rsp_err.
module sccb_master_ctrl
    import sccb_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic               sys_clk,
    input  logic               rst,
    sccb_master_ctrl_if.master bus
);

    sccb_state_e       r_state, w_state_nxt;
    logic [Q_W-1:0]    r_q, w_q_nxt;
    logic [BIT_W-1:0]  r_bit, w_bit_nxt;
    logic [BYTE_W-1:0] r_tx, w_tx_nxt;
    logic [BYTE_W-1:0] r_rx, w_rx_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_busy;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [BYTE_W-1:0] r_rsp_data, w_rsp_data_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    sccb_pad_t         r_pad, w_pad_nxt;
`ifdef SCCB_ACK_CHECK_EN
    logic              r_nack, w_nack_nxt;
`endif

    logic     w_accept;
    logic     w_tick;
    logic     w_illegal;
    sccb_op_e w_op;

    assign w_op      = sccb_op_e'(bus.cmd_op);
    assign w_accept  = bus.cmd_valid && r_ready;
    assign w_illegal = (r_state == ST_IDLE) && (w_op != SCCB_OP_START);

    sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .i_clr    (w_accept),
        .o_tick_c (w_tick)
    );

    // Next state, counters, shift registers and registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_q_nxt         = r_q;
        w_bit_nxt       = r_bit;
        w_tx_nxt        = r_tx;
        w_rx_nxt        = r_rx;
        w_ready_nxt     = r_ready;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_pad_nxt       = r_pad;
`ifdef SCCB_ACK_CHECK_EN
        w_nack_nxt      = r_nack;
`endif

        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept) begin
                    w_q_nxt   = Q0;
                    w_bit_nxt = '0;
                    if (w_illegal) begin
                        // No bus activity, immediate error response
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = '0;
                        w_rsp_err_nxt   = 1'b1;
                    end else begin
                        w_ready_nxt = 1'b0;
                        case (w_op)
                            SCCB_OP_START: begin
                                w_state_nxt = ST_START;
                                w_pad_nxt   = '{sio_c: 1'b0, sio_d_oe: 1'b0, sccb_e: 1'b0};
                            end
                            SCCB_OP_WRITE: begin
                                w_state_nxt = ST_WRITE;
                                w_tx_nxt    = bus.cmd_data;
                                w_pad_nxt   = '{sio_c: 1'b0, sio_d_oe: ~bus.cmd_data[7], sccb_e: 1'b0};
`ifdef SCCB_ACK_CHECK_EN
                                w_nack_nxt  = 1'b0;
`endif
                            end
                            SCCB_OP_READ: begin
                                w_state_nxt = ST_READ;
                                w_rx_nxt    = '0;
                                w_pad_nxt   = '{sio_c: 1'b0, sio_d_oe: 1'b0, sccb_e: 1'b0};
                            end
                            default: begin
                                w_state_nxt = ST_STOP;
                                w_pad_nxt   = '{sio_c: 1'b0, sio_d_oe: 1'b1, sccb_e: 1'b0};
                            end
                        endcase
                    end
                end
            end

            ST_START: begin
                if (w_tick) begin
                    case (r_q)
                        Q0: begin w_q_nxt = Q1; w_pad_nxt.sio_c = 1'b1; end
                        Q1: begin w_q_nxt = Q2; w_pad_nxt.sio_d_oe = 1'b1; end   // SIO_D falls with SIO_C high
                        Q2: begin w_q_nxt = Q3; w_pad_nxt.sio_c = 1'b0; end
                        default: begin
                            w_q_nxt         = Q0;
                            w_state_nxt     = ST_HOLD;
                            w_ready_nxt     = 1'b1;
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_data_nxt  = '0;
                            w_rsp_err_nxt   = 1'b0;
                        end
                    endcase
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    case (r_q)
                        Q0: begin w_q_nxt = Q1; w_pad_nxt.sio_c = 1'b1; end
                        Q1: begin w_q_nxt = Q2; w_pad_nxt.sio_d_oe = 1'b0; end   // SIO_D rises with SIO_C high
                        Q2: begin w_q_nxt = Q3; w_pad_nxt.sccb_e = 1'b1; end
                        default: begin
                            w_q_nxt         = Q0;
                            w_state_nxt     = ST_IDLE;
                            w_ready_nxt     = 1'b1;
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_data_nxt  = '0;
                            w_rsp_err_nxt   = 1'b0;
                        end
                    endcase
                end
            end

            ST_WRITE, ST_READ: begin
                if (w_tick) begin
                    case (r_q)
                        Q0: begin w_q_nxt = Q1; w_pad_nxt.sio_c = 1'b1; end
                        Q1: begin w_q_nxt = Q2; end
                        Q2: begin
                            // Last cycle of q2 is the sample point
                            w_q_nxt         = Q3;
                            w_pad_nxt.sio_c = 1'b0;
                            if ((r_state == ST_READ) && !is_last_bit(r_bit)) begin
                                w_rx_nxt = {r_rx[BYTE_W-2:0], bus.sio_d_i};
                            end
`ifdef SCCB_ACK_CHECK_EN
                            if ((r_state == ST_WRITE) && is_last_bit(r_bit)) begin
                                w_nack_nxt = bus.sio_d_i;
                            end
`endif
                        end
                        default: begin
                            w_q_nxt = Q0;
                            if (is_last_bit(r_bit)) begin
                                w_state_nxt     = ST_HOLD;
                                w_ready_nxt     = 1'b1;
                                w_rsp_valid_nxt = 1'b1;
                                w_rsp_data_nxt  = (r_state == ST_READ) ? r_rx : '0;
`ifdef SCCB_ACK_CHECK_EN
                                w_rsp_err_nxt   = (r_state == ST_WRITE) && r_nack;
`else
                                w_rsp_err_nxt   = 1'b0;
`endif
                            end else begin
                                // Next slot: the ACK/NA slot (bit 9) always releases SIO_D
                                w_bit_nxt          = r_bit + BIT_W'(1);
                                w_tx_nxt           = {r_tx[BYTE_W-2:0], 1'b0};
                                w_pad_nxt.sio_d_oe = (r_state == ST_WRITE) &&
                                                     !is_last_bit(r_bit + BIT_W'(1)) && !r_tx[BYTE_W-2];
                            end
                        end
                    endcase
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_ready_nxt = 1'b1;
                w_pad_nxt   = PAD_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_q         <= Q0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_pad       <= PAD_IDLE;
`ifdef SCCB_ACK_CHECK_EN
            r_nack      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_bit       <= w_bit_nxt;
            r_tx        <= w_tx_nxt;
            r_rx        <= w_rx_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= ~w_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_pad       <= w_pad_nxt;
`ifdef SCCB_ACK_CHECK_EN
            r_nack      <= w_nack_nxt;
`endif
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.sio_c     = r_pad.sio_c;
    assign bus.sio_d_oe  = r_pad.sio_d_oe;
    assign bus.sccb_e    = r_pad.sccb_e;

endmodule

// File: tb/tb_sccb_master_ctrl.sv
// Bench for sccb_master_ctrl: open-drain SIO_D with pull-up, SCCB slave BFM,
// scoreboard queue of expected responses checked by an independent monitor.
module tb_sccb_master_ctrl;
    import sccb_pkg::*;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned LAT_SS   = 4 * CLK_DIV;
    localparam int unsigned LAT_BYTE = 36 * CLK_DIV;
`ifdef SCCB_ACK_CHECK_EN
    localparam logic NACK_ERR = 1'b1;
`else
    localparam logic NACK_ERR = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    sccb_master_ctrl_if bus_if ();

    sccb_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- SCCB slave BFM on an open-drain SIO_D ----------------
    logic       slv_drive = 1'b1;   // 1 = released
    bit         rd_pending = 1'b0;
    bit         rd_arm = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    bit         ack_low = 1'b1;
    int         slot = 0;
    int         rise = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] last_byte = 8'h00;
    logic       last_ack = 1'b1;
    int         n_start = 0;
    int         n_stop = 0;
    bit         in_read = 1'b0;
    int         rd_oe_hi = 0;
    int         n_tog = 0;

    assign bus_if.sio_d_i = ~bus_if.sio_d_oe & slv_drive;
    wire sda = bus_if.sio_d_i;

    always @(negedge sda) begin
        if (bus_if.sio_c === 1'b1) begin
            n_start++;
            slot = 0;
            rise = 0;
            if (rd_pending) begin
                rd_arm     = 1'b1;
                rd_pending = 1'b0;
            end
        end
    end

    always @(posedge sda) begin
        if (bus_if.sio_c === 1'b1) n_stop++;
    end

    // Slave changes SIO_D only while SIO_C is low
    always @(negedge bus_if.sio_c) begin
        if (rd_arm) begin
            slv_drive = (slot < 8) ? rd_byte[7-slot] : 1'b1;
            if (slot == 8) rd_arm = 1'b0;
        end else begin
            slv_drive = (slot == 8 && ack_low) ? 1'b0 : 1'b1;
        end
        slot = (slot == 8) ? 0 : slot + 1;
    end

    always @(posedge bus_if.sio_c) begin
        if (bus_if.sccb_e === 1'b0) begin
            if (rise < 8) shreg = {shreg[6:0], sda};
            if (rise == 7) last_byte = {shreg[6:0]};
            if (rise == 7) last_byte = shreg;
            if (rise == 8) last_ack = sda;
            rise = (rise == 8) ? 0 : rise + 1;
            if (in_read && bus_if.sio_d_oe) rd_oe_hi++;
        end
    end

    always @(bus_if.sio_c or bus_if.sccb_e) n_tog++;

    // ---------------- Scoreboard and monitor ----------------
    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];

    always @(negedge sys_clk) begin
        exp_t ex;
        if (!rst && bus_if.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 data=0x%0h, want no response", bus_if.rsp_data);
            end else begin
                ex = sb.pop_front();
                chk("rsp_data", int'(bus_if.rsp_data), int'(ex.data));
                chk("rsp_err", int'(bus_if.rsp_err), int'(ex.err));
                chk("rsp_latency", cyc - ex.acc, ex.lat);
            end
        end
    end

    // ---------------- Driver ----------------
    task automatic issue(input logic [1:0] op, input logic [7:0] data,
                         input logic [7:0] xd, input logic xe, input int lat);
        int k = 0;
        @(negedge sys_clk);
        while (bus_if.cmd_ready !== 1'b1 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        if (bus_if.cmd_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_ready_timeout: got ready=%b, want 1", bus_if.cmd_ready);
        end else begin
            bus_if.cmd_valid = 1'b1;
            bus_if.cmd_op    = op;
            bus_if.cmd_data  = data;
            @(posedge sys_clk);
            #1;
            sb.push_back('{data: xd, err: xe, lat: lat, acc: cyc});
            // Inputs after accept must be ignored
            bus_if.cmd_valid = 1'b0;
            bus_if.cmd_op    = ~op;
            bus_if.cmd_data  = ~data;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || bus_if.cmd_ready !== 1'b1) && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses, want 0", sb.size());
        end
    endtask

    task automatic clr_bfm();
        n_start = 0;
        n_stop  = 0;
        last_byte = 8'h00;
        last_ack  = 1'b1;
    endtask

    task automatic chk_idle_pads(input string tag);
        chk({tag, "_sio_c"}, int'(bus_if.sio_c), 1);
        chk({tag, "_sio_d_oe"}, int'(bus_if.sio_d_oe), 0);
        chk({tag, "_sccb_e"}, int'(bus_if.sccb_e), 1);
        chk({tag, "_cmd_ready"}, int'(bus_if.cmd_ready), 1);
        chk({tag, "_busy"}, int'(bus_if.busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tog0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = 2'b00;
        bus_if.cmd_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk_idle_pads("reset");
        chk("reset_rsp_valid", int'(bus_if.rsp_valid), 0);
        chk("reset_rsp_data", int'(bus_if.rsp_data), 0);
        chk("reset_rsp_err", int'(bus_if.rsp_err), 0);
        rst = 1'b0;
        @(negedge sys_clk);

        // START, WRITE 0x42, STOP
        clr_bfm();
        ack_low = 1'b1;
        issue(SCCB_OP_START, 8'h00, 8'h00, 1'b0, LAT_SS);
        issue(SCCB_OP_WRITE, 8'h42, 8'h00, 1'b0, LAT_BYTE);
        issue(SCCB_OP_STOP,  8'h00, 8'h00, 1'b0, LAT_SS);
        drain();
        chk("w42_starts", n_start, 1);
        chk("w42_stops", n_stop, 1);
        chk("w42_byte", int'(last_byte), 8'h42);
        chk("w42_ack", int'(last_ack), 0);
        @(negedge sys_clk);
        chk_idle_pads("after_stop");

        // START, READ 0xA5 from slave; ends in HOLD
        clr_bfm();
        rd_byte    = 8'hA5;
        rd_pending = 1'b1;
        issue(SCCB_OP_START, 8'h00, 8'h00, 1'b0, LAT_SS);
        drain();
        in_read = 1'b1;
        issue(SCCB_OP_READ, 8'h3C, 8'hA5, 1'b0, LAT_BYTE);
        drain();
        in_read = 1'b0;
        chk("read_oe_while_sclk_high", rd_oe_hi, 0);
        chk("read_hold_sio_c", int'(bus_if.sio_c), 0);
        chk("read_hold_sccb_e", int'(bus_if.sccb_e), 0);
        chk("read_hold_oe", int'(bus_if.sio_d_oe), 0);
        chk("read_na_slot", int'(last_ack), 1);
        issue(SCCB_OP_STOP, 8'h00, 8'h00, 1'b0, LAT_SS);
        drain();
        chk("read_stops", n_stop, 1);

        // Illegal ops in IDLE: immediate error, no bus activity
        @(negedge sys_clk);
        tog0 = n_tog;
        issue(SCCB_OP_WRITE, 8'h55, 8'h00, 1'b1, 0);
        issue(SCCB_OP_READ,  8'h00, 8'h00, 1'b1, 0);
        issue(SCCB_OP_STOP,  8'h00, 8'h00, 1'b1, 0);
        repeat (20) @(negedge sys_clk);
        drain();
        chk("illegal_no_toggle", n_tog - tog0, 0);
        chk_idle_pads("illegal");

        // Reset during WRITE bit 4
        issue(SCCB_OP_START, 8'h00, 8'h00, 1'b0, LAT_SS);
        issue(SCCB_OP_WRITE, 8'h3C, 8'h00, 1'b0, LAT_BYTE);
        repeat (52) @(posedge sys_clk);
        #3;
        rst = 1'b1;
        #1;
        sb.delete();
        chk_idle_pads("midreset");
        chk("midreset_rsp_valid", int'(bus_if.rsp_valid), 0);
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        clr_bfm();
        issue(SCCB_OP_START, 8'h00, 8'h00, 1'b0, LAT_SS);
        issue(SCCB_OP_WRITE, 8'h0A, 8'h00, 1'b0, LAT_BYTE);
        issue(SCCB_OP_STOP,  8'h00, 8'h00, 1'b0, LAT_SS);
        drain();
        chk("post_reset_byte", int'(last_byte), 8'h0A);
        chk("post_reset_starts", n_start, 1);
        chk("post_reset_stops", n_stop, 1);

        // Slave leaves ACK slot high, then repeated START from HOLD
        clr_bfm();
        ack_low = 1'b0;
        issue(SCCB_OP_START, 8'h00, 8'h00, 1'b0, LAT_SS);
        issue(SCCB_OP_WRITE, 8'h99, 8'h00, NACK_ERR, LAT_BYTE);
        issue(SCCB_OP_START, 8'h00, 8'h00, 1'b0, LAT_SS);
        issue(SCCB_OP_STOP,  8'h00, 8'h00, 1'b0, LAT_SS);
        drain();
        ack_low = 1'b1;
        chk("nack_byte", int'(last_byte), 8'h99);
        chk("nack_ack_level", int'(last_ack), 1);
        chk("nack_starts", n_start, 2);
        chk("nack_stops", n_stop, 1);

        repeat (4) @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
